// File: rtl/fetch_predecode_bp.sv
// Fetch-stage predecoder: classifies jal/jalr/branch/call/return and predicts the
// next PC from a return-address stack and a table of 2-bit branch counters.
module fetch_predecode_bp #(
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned BHT_IDX_W = 6,
    parameter int unsigned USE_BHT   = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         if_valid,
    input  logic                         if_stall,
    input  logic [31:0]                  if_pc,
    input  logic [31:0]                  if_instr,
    input  logic                         ex_flush,
    input  logic                         ex_bxx_valid,
    input  logic [31:0]                  ex_bxx_pc,
    input  logic                         ex_bxx_taken,
    output logic                         isjal,
    output logic                         isjalr,
    output logic                         isbxx,
    output logic                         iscall,
    output logic                         isret,
    output logic                         pred_redirect,
    output logic [31:0]                  pred_target,
    output logic [$clog2(RAS_DEPTH):0]   ras_count
);

    localparam int unsigned PTR_W   = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned BHT_NUM = 1 << BHT_IDX_W;

    logic [31:0]          ras_q [RAS_DEPTH];
    logic [31:0]          ras_d [RAS_DEPTH];
    logic [PTR_W-1:0]     top_q, top_d, top_inc;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           bht_q [BHT_NUM];
    logic [1:0]           bht_d [BHT_NUM];

    logic [4:0]           rd, rs1;
    logic                 rd_link, rs1_link;
    logic [31:0]          jal_imm, bxx_imm, link_pc;
    logic [BHT_IDX_W-1:0] rd_idx, wr_idx;
    logic                 taken, fire, do_push, do_pop;
    logic                 unused_pc_bits;

    assign rd             = if_instr[11:7];
    assign rs1            = if_instr[19:15];
    assign rd_link        = (rd == 5'd1) || (rd == 5'd5);
    assign rs1_link       = (rs1 == 5'd1) || (rs1 == 5'd5);
    assign jal_imm        = {{12{if_instr[31]}}, if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};
    assign bxx_imm        = {{20{if_instr[31]}}, if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
    assign link_pc        = if_pc + 32'd4;
    assign rd_idx         = if_pc[BHT_IDX_W+1:2];
    assign wr_idx         = ex_bxx_pc[BHT_IDX_W+1:2];
    assign unused_pc_bits = ^{ex_bxx_pc[31:BHT_IDX_W+2], ex_bxx_pc[1:0]};
    assign ras_count      = cnt_q;

    always_comb begin
        isjal  = if_valid && (if_instr[6:0] == 7'h6F);
        isjalr = if_valid && (if_instr[6:0] == 7'h67);
        isbxx  = if_valid && (if_instr[6:0] == 7'h63);
        iscall = (isjal || isjalr) && rd_link;
        isret  = isjalr && rs1_link && !(rd_link && (rd == rs1));
        taken  = (USE_BHT != 0) ? bht_q[rd_idx][1] : if_instr[31];

        pred_redirect = 1'b0;
        pred_target   = link_pc;
        if (isjal) begin
            pred_redirect = 1'b1;
            pred_target   = if_pc + jal_imm;
        end else if (isret && (cnt_q != '0)) begin
            pred_redirect = 1'b1;
            pred_target   = ras_q[top_q];
        end else if (isbxx && taken) begin
            pred_redirect = 1'b1;
            pred_target   = if_pc + bxx_imm;
        end
    end

    // A swap (pop+push) on a non-empty stack rewrites the top in place;
    // on an empty stack the pop is a no-op, so it degrades to a plain push.
    always_comb begin
        fire    = if_valid && !if_stall && !ex_flush;
        do_push = fire && iscall;
        do_pop  = fire && isret && (cnt_q != '0);
        top_inc = top_q + 1'b1;
        ras_d   = ras_q;
        top_d   = top_q;
        cnt_d   = cnt_q;
        if (ex_flush) begin
            top_d = '0;
            cnt_d = '0;
        end else if (do_push && do_pop) begin
            ras_d[top_q] = link_pc;
        end else if (do_push) begin
            ras_d[top_inc] = link_pc;
            top_d          = top_inc;
            if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + 1'b1;
        end else if (do_pop) begin
            top_d = top_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_comb begin
        bht_d = bht_q;
        if (ex_bxx_valid) begin
            if (ex_bxx_taken && (bht_q[wr_idx] != 2'b11))
                bht_d[wr_idx] = bht_q[wr_idx] + 2'd1;
            else if (!ex_bxx_taken && (bht_q[wr_idx] != 2'b00))
                bht_d[wr_idx] = bht_q[wr_idx] - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
            for (int unsigned i = 0; i < BHT_NUM; i++) bht_q[i] <= 2'b01;
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            ras_q <= ras_d;
            bht_q <= bht_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: doc/fetch_predecode_bp.md
# fetch_predecode_bp

Fetch-stage predecoder and branch predictor. It sits between the instruction fetch buffer and the PC-select mux. It classifies the fetched 32-bit instruction (jal / jalr / branch / call / return) and produces a predicted next PC. Prediction uses a parametrised return-address stack (RAS) and a parametrised branch history table (BHT) of 2-bit counters, which EXE updates on branch resolution. It replaces the static sign-bit prediction and register-based jalr target path of the previous fetch decoder.

## Interface
Parameters:
- RAS_DEPTH, 4: RAS entries; power of two, 2..16.
- BHT_IDX_W, 6: log2 of BHT entries; 2..10.
- USE_BHT, 1: 1 = conditional branches predicted by BHT counter; 0 = static (taken iff instr[31]=1, backward).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_valid  in  1  if_instr/if_pc hold a valid instruction.
- if_stall  in  1  fetch held this cycle; no predictor state change.
- if_pc  in  32  PC of if_instr.
- if_instr  in  32  fetched instruction.
- ex_flush  in  1  EXE redirect (mispredict/trap); clears RAS, suppresses fire.
- ex_bxx_valid  in  1  a conditional branch resolved in EXE this cycle.
- ex_bxx_pc  in  32  PC of the resolved branch.
- ex_bxx_taken  in  1  resolved direction.
- isjal, isjalr, isbxx  out  1  opcode class (gated by if_valid).
- iscall, isret  out  1  link-register call / return classification (gated by if_valid).
- pred_redirect  out  1  fetch must go to pred_target instead of if_pc+4.
- pred_target  out  32  predicted next PC.
- ras_count  out  $clog2(RAS_DEPTH)+1  current valid RAS entries.

## Operation
- Link registers are x1 and x5. rd = instr[11:7], rs1 = instr[19:15]. Opcodes: JAL 7'h6F, JALR 7'h67, BRANCH 7'h63.
- Calls and returns:
  - iscall = (isjal|isjalr) & rd∈{x1,x5}.
  - isret = isjalr & rs1∈{x1,x5} & ~(rd∈{x1,x5} & rd==rs1).
  - Both call and return (rd and rs1 are different link registers) = pop then push (coroutine swap).
- fire = if_valid & ~if_stall & ~ex_flush. RAS changes only when fire is 1.
- RAS structure: circular array with top pointer and count.
  - Push writes if_pc+4 at top+1, advances top, and saturates count at RAS_DEPTH. Pushing when full overwrites the oldest entry.
  - Pop retreats top and decrements count. Pop when empty does nothing.
  - Pop+push in one fire: the top entry is replaced by if_pc+4 and count is unchanged. If the RAS is empty, pop+push behaves as a plain push.
- ex_flush clears count and top to 0 in the same edge. Entry contents are not cleared.
- Offsets: jal imm = {instr[31],instr[19:12],instr[20],instr[30:21],0}; branch imm = {instr[31],instr[7],instr[30:25],instr[11:8],0}. Both are sign-extended to 32 bits. All adds are mod 2^32.
- BHT: 2^BHT_IDX_W 2-bit saturating counters.
  - Read index = if_pc[BHT_IDX_W+1:2].
  - Update index = ex_bxx_pc[BHT_IDX_W+1:2].
  - On ex_bxx_valid: increment toward 3 if taken, decrement toward 0 if not. The update is independent of if_stall and ex_flush.
  - Prediction taken = counter[1].
- Target priority (when if_valid):
  1. isjal → if_pc+jal_imm, redirect=1.
  2. isret & ras_count>0 → RAS top, redirect=1.
  3. isbxx & taken → if_pc+branch_imm, redirect=1.
  4. Otherwise → if_pc+4, redirect=0. This includes a non-return jalr, and a return when the RAS is empty; those resolve in EXE.
- When if_valid=0, all classification outputs and pred_redirect are 0, and pred_target = if_pc+4.

## Timing
- All outputs except ras_count are combinational from if_* inputs plus current state: zero-cycle prediction.
- State updates take effect at the next rising edge. A return in cycle N+1 sees a call pushed in cycle N.
- A BHT write and a read of the same index in the same cycle: the read returns the old counter. The new value is visible next cycle.
- Reset values:
  - all RAS entries 0, top 0, ras_count 0;
  - all BHT counters 2'b01 (weakly not-taken);
  - outputs follow their combinational rules with empty state.
- Reset asserted mid-operation clears state immediately, independent of clk.

## Test plan
- Call/return: jal x1,+0x100 at pc 0x1000 → pred_target 0x1100, ras_count 1. Next, jalr x0,0(x1) at 0x1100 → isret=1, pred_target 0x1004, redirect=1, ras_count 0.
- RAS overflow (DEPTH=4): 5 calls from pcs 0x0,0x10,0x20,0x30,0x40 → count stays 4. Then 5 returns predict 0x44,0x34,0x24,0x14, and the 5th has redirect=0 (empty).
- Swap and push-only cases:
  - jalr x5,0(x1) with count 2 → count stays 2, top = pc+4.
  - jalr x1,0(x1) → push only, count+1.
- BHT training: 2 taken updates on pc 0x2000 → branch at 0x2000 goes 01→10→11; predicted taken from the cycle after the first update, target = pc+imm.
- USE_BHT=0: beq with instr[31]=1 predicts taken and with instr[31]=0 predicts not taken, regardless of updates.
- Hazards:
  - if_stall=1 on a call → no push.
  - ex_flush=1 with a call present → count 0, no push.
  - rst_n low mid-run → count 0 and BHT counters 01 asynchronously.
